// File: rtl/dcp_pkg.sv
// Shared types and helpers for the DCP print path: controller states,
// ASCII constants, payload type codes and the nibble-to-ASCII conversion.
package dcp_pkg;

    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_ACK
    } state_t;

    localparam logic [CHAR_W-1:0] ASCII_ZERO = 8'h30;
    localparam logic [CHAR_W-1:0] ASCII_A    = 8'h41;
    localparam logic [CHAR_W-1:0] ASCII_CR   = 8'h0D;
    localparam logic [CHAR_W-1:0] ASCII_LF   = 8'h0A;

    localparam logic TYPE_BYTE = 1'b0;
    localparam logic TYPE_WORD = 1'b1;

    // Uppercase hex digit for one nibble.
    function automatic logic [CHAR_W-1:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + CHAR_W'(nib);
        end
        return ASCII_A + CHAR_W'(nib - 4'd10);
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. A start pulse loads {stop, data, start} into a
// 10-bit shifter whose LSB drives the line; each bit lasts DIV cycles.
// Ports: clk, rst (async active-low), start (load a byte, accepted even on
//        the done cycle so frames can run back-to-back), data, txd,
//        bit_end_c (last cycle of the current bit), done_c (last stop cycle).
module uart_tx_byte
    import dcp_pkg::*;
#(
    parameter int unsigned DIV = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAR_W-1:0] data,
    output logic              txd,
    output logic              bit_end_c,
    output logic              done_c
);

    localparam int unsigned BAUD_W    = 16;
    localparam int unsigned BIT_W     = 4;
    localparam int unsigned FRAME_W   = 10;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(FRAME_W - 1);

    logic                  active_q;
    logic [BAUD_W-1:0]     baud_q;
    logic [BIT_W-1:0]      bit_q;
    logic [FRAME_W-1:0]    shift_q;

    assign bit_end_c = active_q && (baud_q == BAUD_MAX);
    assign done_c    = bit_end_c && (bit_q == LAST_BIT);
    // Line comes straight off a flop: glitch-free, idles high via the 1-fill.
    assign txd       = shift_q[0];

    // Baud counter, bit counter and shifter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
        end else if (start) begin
            active_q <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= {1'b1, data, 1'b0};
        end else if (active_q) begin
            if (bit_end_c) begin
                baud_q  <= '0;
                shift_q <= {1'b1, shift_q[FRAME_W-1:1]};
                if (bit_q == LAST_BIT) begin
                    active_q <= 1'b0;
                    bit_q    <= '0;
                end else begin
                    bit_q <= bit_q + BIT_W'(1);
                end
            end else begin
                baud_q <= baud_q + BAUD_W'(1);
            end
        end
    end

endmodule

// File: rtl/dcp_tx_print.sv
// DCP print unit: latches a request, sends either one raw byte or a 32-bit
// word as eight uppercase hex characters over a UART line, then acks.
// Ports: clk, rst (async active-low), req_tx (level request, sampled in
//        IDLE), type_tx (0 byte / 1 word), din_tx (payload), ack_tx (one-cycle
//        completion pulse), busy (request in flight), txd (8N1 line).
module dcp_tx_print
    import dcp_pkg::*;
#(
    parameter int unsigned DIV = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tx,
    input  logic              type_tx,
    input  logic [WORD_W-1:0] din_tx,
    output logic              ack_tx,
    output logic              busy,
    output logic              txd
);

    state_t              state_q, state_d;
    logic                type_q, type_d;
    logic [WORD_W-1:0]   din_q, din_d;
    logic [IDX_W-1:0]    char_idx_q, char_idx_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic                ack_d;
    logic                busy_d;

    logic                start_c;
    logic [CHAR_W-1:0]   tx_data_c;
    logic                bit_end_c;
    logic                done_c;

    logic [IDX_W-1:0]    next_idx_c;
    logic [4:0]          nib_sh_c;
    logic [3:0]          next_nib_c;

    // Nibble of the latched word for the character after the current one.
    assign next_idx_c = char_idx_q + IDX_W'(1);
    assign nib_sh_c   = 5'd28 - {next_idx_c, 2'b00};
    assign next_nib_c = 4'(din_q >> nib_sh_c);

    uart_tx_byte #(
        .DIV (DIV)
    ) u_uart (
        .clk       (clk),
        .rst       (rst),
        .start     (start_c),
        .data      (tx_data_c),
        .txd       (txd),
        .bit_end_c (bit_end_c),
        .done_c    (done_c)
    );

    // State, latches and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            type_q     <= 1'b0;
            din_q      <= '0;
            char_idx_q <= '0;
            bit_idx_q  <= '0;
            ack_tx     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            din_q      <= din_d;
            char_idx_q <= char_idx_d;
            bit_idx_q  <= bit_idx_d;
            ack_tx     <= ack_d;
            busy       <= busy_d;
        end
    end

    // Next-state and transmitter control. The UART is started on the same
    // edge that accepts a request (or ends a stop bit) so the start bit
    // appears on the very next cycle.
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        din_d      = din_q;
        char_idx_d = char_idx_q;
        bit_idx_d  = bit_idx_q;
        ack_d      = 1'b0;
        start_c    = 1'b0;
        tx_data_c  = nibble_to_ascii(next_nib_c);

        case (state_q)
            ST_IDLE: begin
                if (req_tx) begin
                    type_d     = type_tx;
                    din_d      = din_tx;
                    char_idx_d = '0;
                    bit_idx_d  = '0;
                    start_c    = 1'b1;
                    tx_data_c  = (type_tx == TYPE_WORD) ? nibble_to_ascii(din_tx[31:28])
                                                        : din_tx[7:0];
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end_c) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    if (bit_idx_q == IDX_W'(7)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (done_c) begin
                    if ((type_q == TYPE_WORD) && (char_idx_q != IDX_W'(7))) begin
                        char_idx_d = next_idx_c;
                        start_c    = 1'b1;
                        state_d    = ST_START;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_dcp_tx_print.sv
// Bench for dcp_tx_print with DIV=4: table vectors, random payloads against a
// string-formatting reference model, back-to-back requests and mid-frame reset.
module tb_dcp_tx_print;

    localparam int unsigned DIV = 4;

    logic        clk;
    logic        rst;
    logic        req_tx;
    logic        type_tx;
    logic [31:0] din_tx;
    logic        ack_tx;
    logic        busy;
    logic        txd;

    int tests;
    int fails;

    dcp_tx_print #(.DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_tx  (req_tx),
        .type_tx (type_tx),
        .din_tx  (din_tx),
        .ack_tx  (ack_tx),
        .busy    (busy),
        .txd     (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        t;
        logic [31:0] d;
        int          n;
        logic [63:0] bytes;   // first character in [63:56]
        string       name;
    } vec_t;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: raw byte, or the word printed as uppercase hex text.
    function automatic logic [63:0] model_bytes(input logic t, input logic [31:0] d, output int n);
        string       s;
        logic [7:0]  ch;
        logic [63:0] r;
        r = '0;
        if (t == 1'b0) begin
            n = 1;
            return {d[7:0], 56'h0};
        end
        n = 8;
        s = $sformatf("%h", d);
        for (int i = 0; i < 8; i++) begin
            ch = s[i];
            if (ch >= 8'h61) ch = ch - 8'd32;
            r = {r[55:0], ch};
        end
        return r;
    endfunction

    // Expected line level k cycles after the accepting edge (k >= 1).
    function automatic logic exp_bit(input logic [63:0] bytes, input int n, input int k);
        int          b, c, p;
        logic [63:0] sh;
        logic [7:0]  ch;
        if (k < 1 || k > n * 10 * int'(DIV)) return 1'b1;
        b  = (k - 1) / int'(DIV);
        c  = b / 10;
        p  = b % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        sh = bytes << (8 * c);
        ch = sh[63:56];
        return ch[p - 1];
    endfunction

    // One full request: accept, then compare every cycle through ack+1.
    task automatic run_xfer(input logic t, input logic [31:0] d, input logic [63:0] bytes,
                            input int n, input string name);
        int last, txd_err, first_bad, ack_cnt, ack_at, busy_err;
        last = n * 10 * int'(DIV) + 1;
        txd_err = 0; first_bad = -1; ack_cnt = 0; ack_at = -1; busy_err = 0;
        @(negedge clk);
        req_tx = 1'b1; type_tx = t; din_tx = d;
        @(posedge clk);
        #1 req_tx = 1'b0;
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge clk);
            if (txd !== exp_bit(bytes, n, k)) begin
                txd_err++;
                if (first_bad < 0) first_bad = k;
            end
            if (ack_tx === 1'b1) begin
                ack_cnt++;
                ack_at = k;
            end
            if (busy !== (k <= last)) busy_err++;
            // Payload changes after latching must not leak into the frame.
            if (k == 3 * int'(DIV) + 2) begin
                din_tx  = $urandom;
                type_tx = ~t;
            end
        end
        check(txd_err == 0, {name, " txd"}, txd_err, 0);
        check(ack_cnt == 1 && ack_at == last, {name, " ack"}, ack_at, last);
        check(busy_err == 0, {name, " busy"}, busy_err, 0);
    endtask

    vec_t        vecs[6];
    logic [63:0] rb;
    int          rn;
    logic        rt;
    logic [31:0] rd;
    logic        tr[1:100];
    logic        ar[1:100];
    logic        br[1:100];
    int          e_txd, e_ack, e_busy, e_quiet;
    logic        eb;

    initial begin
        tests = 0; fails = 0;
        rst = 1'b0; req_tx = 1'b0; type_tx = 1'b0; din_tx = '0;

        vecs[0] = '{1'b0, 32'h0000_0041, 1, 64'h4100_0000_0000_0000, "byte41"};
        vecs[1] = '{1'b1, 32'h0000_0716, 8, 64'h3030_3030_3037_3136, "word716"};
        vecs[2] = '{1'b1, 32'hDEAD_BEEF, 8, 64'h4445_4144_4245_4546, "deadbeef"};
        vecs[3] = '{1'b0, 32'hFFFF_FF00, 1, 64'h0000_0000_0000_0000, "byte00"};
        vecs[4] = '{1'b0, 32'h1234_56FF, 1, 64'hFF00_0000_0000_0000, "byteFF"};
        vecs[5] = '{1'b1, 32'h09AF_F0A9, 8, 64'h3039_4146_4630_4139, "word09af"};

        // Reset values while held.
        repeat (3) @(negedge clk);
        check(txd === 1'b1, "rst txd", txd, 1);
        check(ack_tx === 1'b0, "rst ack", ack_tx, 0);
        check(busy === 1'b0, "rst busy", busy, 0);
        rst = 1'b1;

        foreach (vecs[i]) run_xfer(vecs[i].t, vecs[i].d, vecs[i].bytes, vecs[i].n, vecs[i].name);

        // Random payloads against the reference model.
        for (int i = 0; i < 8; i++) begin
            rt = 1'($urandom_range(0, 1));
            rd = $urandom;
            rb = model_bytes(rt, rd, rn);
            run_xfer(rt, rd, rb, rn, $sformatf("rand%0d", i));
        end

        // req_tx held through ACK: second frame takes din at the post-ACK IDLE edge.
        @(negedge clk);
        req_tx = 1'b1; type_tx = 1'b0; din_tx = 32'h41;
        @(posedge clk);
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            tr[k] = txd; ar[k] = ack_tx; br[k] = busy;
            if (k == 10) din_tx = 32'h0D;
            if (k == 30) din_tx = 32'h0A;
            if (k == 50) req_tx = 1'b0;
        end
        e_txd = 0; e_ack = 0; e_busy = 0;
        for (int k = 1; k <= 90; k++) begin
            if (k <= 42) eb = exp_bit(64'h4100_0000_0000_0000, 1, k);
            else         eb = exp_bit(64'h0A00_0000_0000_0000, 1, k - 42);
            if (tr[k] !== eb) e_txd++;
            if (ar[k] !== (k == 41 || k == 83)) e_ack++;
            if (br[k] !== ((k <= 41) || (k >= 43 && k <= 83))) e_busy++;
        end
        check(e_txd == 0, "b2b txd", e_txd, 0);
        check(e_ack == 0, "b2b ack", e_ack, 0);
        check(e_busy == 0, "b2b busy", e_busy, 0);

        // Reset in the middle of the second character's data bits.
        @(negedge clk);
        req_tx = 1'b1; type_tx = 1'b1; din_tx = 32'h1234_5678;
        @(posedge clk);
        #1 req_tx = 1'b0;
        repeat (13 * DIV) @(negedge clk);
        check(busy === 1'b1, "pre-rst busy", busy, 1);
        rst = 1'b0;
        #1;
        check(txd === 1'b1, "midrst txd", txd, 1);
        check(busy === 1'b0, "midrst busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        e_quiet = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ack_tx !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) e_quiet++;
        end
        check(e_quiet == 0, "post-rst quiet", e_quiet, 0);
        run_xfer(vecs[0].t, vecs[0].d, vecs[0].bytes, vecs[0].n, "after-rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dcp_tx_print.md
DCP_TX_PRINT -- requirements
Module: dcp_tx_print

Interface
REQ-001 Parameter DIV, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 req_tx  input  1  print request from a DCP command unit; level, sampled only in IDLE.
REQ-005 type_tx  input  1  0 = one raw byte, 1 = 32-bit word as 8 ASCII hex characters.
REQ-006 din_tx  input  32  payload; type 0 uses din_tx[7:0], type 1 uses all 32 bits.
REQ-007 ack_tx  output  1  one-cycle pulse when the request has been fully transmitted.
REQ-008 busy  output  1  high from request acceptance until the ack_tx cycle, inclusive.
REQ-009 txd  output  1  UART serial line, 8N1, LSB first, idle high.

Function
REQ-010 States: IDLE, START, DATA, STOP, ACK.
REQ-011 IDLE: rising edge with req_tx=1 latches type_tx and din_tx, clears char index, enters START; req_tx=0 stays IDLE.
REQ-012 din_tx/type_tx changes after latching have no effect on the transfer in progress.
REQ-013 txd is low starting the cycle after the accepting edge (START), for exactly DIV cycles.
REQ-014 DATA: 8 bits, LSB first, each held exactly DIV cycles; STOP: txd high for exactly DIV cycles.
REQ-015 Type 0 character = latched din[7:0], transmitted unmodified.
REQ-016 Type 1: characters ordered from nibble [31:28] down to [3:0]; 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
REQ-017 STOP end: if characters remain (type 1, index < 7), increment index and enter START with no idle gap; otherwise enter ACK.
REQ-018 ACK: ack_tx=1 for exactly one cycle, txd=1, then IDLE; req_tx is ignored during ACK.
REQ-019 Type 0 frame: ack_tx is high at cycle 10*DIV+1 after the accepting edge; type 1 at 80*DIV+1.
REQ-020 A requester holding req_tx high through ACK starts a new transfer at the first IDLE edge (back-to-back; one idle cycle between frames).
REQ-021 Baud counter counts 0..DIV-1 and wraps; bit index 0..7 and char index 0..7 are 3-bit, never overflow.
REQ-022 busy = (state != IDLE); txd is registered (no glitches).

Reset
REQ-023 While rst=0: state IDLE, txd=1, ack_tx=0, busy=0, all counters and latches 0.
REQ-024 Reset mid-frame aborts immediately; no ack_tx is produced for the aborted request.
REQ-025 After rst deasserts, the first request is accepted on the first rising edge with req_tx=1.

Structure
REQ-026 Shared package dcp_pkg holds: state enum, ASCII constants (0x30, 0x41, CR 0x0D, LF 0x0A), nibble-to-ASCII function, type codes TYPE_BYTE=0 / TYPE_WORD=1.
REQ-027 One sub-module uart_tx_byte (baud counter, 10-bit shifter, start/done handshake); dcp_tx_print owns request latch, hex sequencing and ack.

Verification (benches use DIV=4)
REQ-028 type 0, din=0x00000041 -> txd sequence 0,1,0,0,0,0,0,1,0,1 (4 cycles each); ack_tx at cycle 41.
REQ-029 type 1, din=0x00000716 -> bytes 30 30 30 30 30 37 31 36 back-to-back; single ack_tx at cycle 321.
REQ-030 type 1, din=0xDEADBEEF -> bytes 44 45 41 44 42 45 45 46 ("DEADBEEF").
REQ-031 req_tx held high, din changed to 0x0D then 0x0A during the first frame (type 0) -> second frame carries the value present at the post-ACK IDLE edge; exactly one ack_tx per frame.
REQ-032 rst pulsed low mid-DATA of a type 1 transfer -> txd=1, busy=0 same cycle; no ack_tx; next request transmits normally.
REQ-033 din_tx changed during DATA -> transmitted bytes match the latched value.
